// File: rtl/cdb_wb_arb.sv
// Writeback arbiter for the common data bus: one-entry slot per FU, one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
`ifndef PRF_IDX_W
`define PRF_IDX_W 7
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

module cdb_wb_arb #(
  parameter int FU_NUM = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic [FU_NUM-1:0]                    fu_valid_i,
  input  logic [FU_NUM-1:0][`PRF_IDX_W-1:0]    fu_tag_i,
  input  logic [FU_NUM-1:0][63:0]              fu_data_i,
  input  logic [FU_NUM-1:0][`ROB_IDX_W-1:0]    fu_rob_idx_i,
  output logic [FU_NUM-1:0]                    fu_ready_o,
  output logic                                 cdb_valid_o,
  output logic [`PRF_IDX_W-1:0]                cdb_tag_o,
  output logic [63:0]                          cdb_data_o,
  output logic [`ROB_IDX_W-1:0]                cdb_rob_idx_o,
  output logic                                 prf_wr_en_o
);

  localparam logic [`PRF_IDX_W-1:0] ZERO_TAG = `PRF_IDX_W'(`ZERO_REG);

  // Handshake: a result transfers into slot i at the posedge when
  // fu_valid_i[i] & fu_ready_o[i]; ready never looks at fu_valid_i.
  logic [FU_NUM-1:0]     slot_v_q, slot_v_d;
  logic [`PRF_IDX_W-1:0] slot_tag_q  [FU_NUM];
  logic [63:0]           slot_data_q [FU_NUM];
  logic [`ROB_IDX_W-1:0] slot_rob_q  [FU_NUM];

  logic [FU_NUM-1:0]     grant;
  logic [FU_NUM-1:0]     load;
  logic                  any_grant;
  logic [`PRF_IDX_W-1:0] win_tag;
  logic [63:0]           win_data;
  logic [`ROB_IDX_W-1:0] win_rob;

  logic                  cdb_valid_q, cdb_valid_d;
  logic                  prf_wr_en_q, prf_wr_en_d;
  logic [`PRF_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [63:0]           cdb_data_q, cdb_data_d;
  logic [`ROB_IDX_W-1:0] cdb_rob_q, cdb_rob_d;

`ifdef CDB_RR_EN
  localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;

  always_comb begin
    int idx;
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx = (int'(ptr_q) + k) % FU_NUM;
      if (!any_grant && slot_v_q[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

  // A flushed cycle leaves the pointer where it was even if a slot won.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant && !flush_i) begin
      ptr_d = (gidx == PTR_W'(FU_NUM - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (!any_grant && slot_v_q[i]) begin
        grant[i]  = 1'b1;
        any_grant = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    win_rob  = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (grant[i]) begin
        win_tag  = slot_tag_q[i];
        win_data = slot_data_q[i];
        win_rob  = slot_rob_q[i];
      end
    end
  end

  assign fu_ready_o = ~slot_v_q | grant;
  assign load       = fu_valid_i & fu_ready_o & {FU_NUM{~flush_i}};

  always_comb begin
    slot_v_d = (slot_v_q & ~grant) | load;
    if (flush_i) slot_v_d = '0;
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    prf_wr_en_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_rob_d   = cdb_rob_q;
    if (!flush_i && any_grant) begin
      cdb_valid_d = 1'b1;
      prf_wr_en_d = (win_tag != ZERO_TAG);
      cdb_tag_d   = win_tag;
      cdb_data_d  = win_data;
      cdb_rob_d   = win_rob;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v_q    <= '0;
      cdb_valid_q <= 1'b0;
      prf_wr_en_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_rob_q   <= '0;
    end else begin
      slot_v_q    <= slot_v_d;
      cdb_valid_q <= cdb_valid_d;
      prf_wr_en_q <= prf_wr_en_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_rob_q   <= cdb_rob_d;
    end
  end

  // Slot payload is qualified by slot_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (load[i]) begin
        slot_tag_q[i]  <= fu_tag_i[i];
        slot_data_q[i] <= fu_data_i[i];
        slot_rob_q[i]  <= fu_rob_idx_i[i];
      end
    end
  end

  assign cdb_valid_o   = cdb_valid_q;
  assign prf_wr_en_o   = prf_wr_en_q;
  assign cdb_tag_o     = cdb_tag_q;
  assign cdb_data_o    = cdb_data_q;
  assign cdb_rob_idx_o = cdb_rob_q;

endmodule

// File: tb/tb_cdb_wb_arb.sv
// Self-checking bench for cdb_wb_arb: directed scenarios plus random traffic against a slot/queue reference model.
`ifndef PRF_IDX_W
`define PRF_IDX_W 7
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

module tb_cdb_wb_arb;
  localparam int N  = 4;
  localparam int PW = `PRF_IDX_W;
  localparam int RW = `ROB_IDX_W;
  localparam logic [PW-1:0] ZTAG = PW'(`ZERO_REG);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   flush_i = 1'b0;
  logic [N-1:0]           fu_valid = '0;
  logic [N-1:0][PW-1:0]   fu_tag = '0;
  logic [N-1:0][63:0]     fu_data = '0;
  logic [N-1:0][RW-1:0]   fu_rob = '0;
  logic [N-1:0]           fu_ready_o;
  logic                   cdb_valid_o;
  logic [PW-1:0]          cdb_tag_o;
  logic [63:0]            cdb_data_o;
  logic [RW-1:0]          cdb_rob_idx_o;
  logic                   prf_wr_en_o;

  cdb_wb_arb #(.FU_NUM(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .fu_valid_i   (fu_valid),
    .fu_tag_i     (fu_tag),
    .fu_data_i    (fu_data),
    .fu_rob_idx_i (fu_rob),
    .fu_ready_o   (fu_ready_o),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_tag_o    (cdb_tag_o),
    .cdb_data_o   (cdb_data_o),
    .cdb_rob_idx_o(cdb_rob_idx_o),
    .prf_wr_en_o  (prf_wr_en_o)
  );

  // reference model: one slot per FU and the broadcast register
  logic [N-1:0]  m_v;
  logic [PW-1:0] m_tag [N];
  logic [63:0]   m_data [N];
  logic [RW-1:0] m_rob [N];
  int            m_ptr;
  logic          m_cv, m_prf;
  logic [PW-1:0] m_ctag;
  logic [63:0]   m_cdata;
  logic [RW-1:0] m_crob;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef CDB_RR_EN
      idx = (m_ptr + k) % N;
`else
      idx = k;
`endif
      if (m_v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_grant();
    r = ~m_v;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    m_v = '0; m_cv = 1'b0; m_prf = 1'b0;
    m_ctag = '0; m_cdata = '0; m_crob = '0; m_ptr = 0;
  endtask

  // driver tasks
  task automatic offer(input int i, input logic [PW-1:0] t, input logic [63:0] d, input logic [RW-1:0] r);
    fu_valid[i] = 1'b1; fu_tag[i] = t; fu_data[i] = d; fu_rob[i] = r;
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  // One clock: model follows the same edge, caller resumes at the next negedge.
  task automatic tick();
    int g;
    logic [N-1:0] rdy;
    g   = m_grant();
    rdy = m_ready();
    @(posedge clk);
    if (rst) m_reset();
    else if (flush_i) begin
      m_v = '0; m_cv = 1'b0; m_prf = 1'b0;
    end else begin
      if (g >= 0) begin
        m_cv = 1'b1; m_ctag = m_tag[g]; m_cdata = m_data[g]; m_crob = m_rob[g];
        m_prf = (m_tag[g] != ZTAG);
        m_v[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end else begin
        m_cv = 1'b0; m_prf = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && rdy[i]) begin
          m_v[i] = 1'b1; m_tag[i] = fu_tag[i]; m_data[i] = fu_data[i]; m_rob[i] = fu_rob[i];
        end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    idle();
    flush_i = 1'b0;
    #2 rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    offer(0, PW'(3), 64'h1111, RW'(1));
    offer(1, PW'(4), 64'h2222, RW'(2));
    tick();
    idle();
    tick();
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
      n_fail++; $display("FAIL pre_reset_cdb cyc %0d got %h want %h", cyc,
        {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== '0) begin
      n_fail++; $display("FAIL async_reset_outputs got %h want 0", {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o});
    end
    n_cmp++;
    if (fu_ready_o !== 4'b1111) begin
      n_fail++; $display("FAIL async_reset_ready got %b want 1111", fu_ready_o);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
        n_fail++; $display("FAIL post_reset_idle cyc %0d got %h want %h", cyc,
          {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
      end
    end
  endtask

  task automatic test_single_offer();
    offer(2, PW'(7), 64'hDEAD, RW'(3));
    tick();
    idle();
    n_cmp++;
    if (cdb_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_latency got valid %b want 0", cdb_valid_o);
    end
    tick();
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_data_o, cdb_rob_idx_o} !== {1'b1, 1'b1, PW'(7), 64'hDEAD, RW'(3)}) begin
      n_fail++; $display("FAIL single_broadcast got v=%b w=%b tag=%0d data=%h rob=%0d want 1 1 7 dead 3",
        cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_data_o, cdb_rob_idx_o);
    end
    tick();
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL single_drop got v=%b w=%b want 0 0", cdb_valid_o, prf_wr_en_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    exp_q.delete(); obs_q.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_q.push_back(PW'(10 + i));
    for (int i = 0; i < N; i++) offer(i, PW'(10 + i), {$urandom, $urandom}, RW'(i));
    tick();
    for (int c = 0; c < 9; c++) begin
      if (c == 3) for (int i = 0; i < N; i++) offer(i, PW'(10 + i), {$urandom, $urandom}, RW'(4 + i));
      else idle();
      #1;
      n_cmp++;
      if (fu_ready_o !== m_ready()) begin
        n_fail++; $display("FAIL contention_ready cyc %0d got %b want %b", cyc, fu_ready_o, m_ready());
      end
      tick();
      if (cdb_valid_o) obs_q.push_back(cdb_tag_o);
      n_cmp++;
      if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
        n_fail++; $display("FAIL contention_cdb cyc %0d got %h want %h", cyc,
          {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL contention_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [PW-1:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL contention_order got tag %0d want %0d", o, e);
      end
    end
  endtask

  task automatic test_starve();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      offer(0, PW'(20 + c), {$urandom, $urandom}, RW'(c));
      if (c == 0) offer(3, PW'(40), 64'h4040, RW'(7));
      else fu_valid[3] = 1'b0;
      #1;
      n_cmp++;
      if (fu_ready_o !== m_ready()) begin
        n_fail++; $display("FAIL starve_ready cyc %0d got %b want %b", cyc, fu_ready_o, m_ready());
      end
`ifndef CDB_RR_EN
      if (c >= 1) begin
        n_cmp++;
        if (fu_ready_o[3] !== 1'b0) begin
          n_fail++; $display("FAIL starve_ready3 cyc %0d got %b want 0", cyc, fu_ready_o[3]);
        end
      end
`endif
      tick();
      n_cmp++;
      if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
        n_fail++; $display("FAIL starve_cdb cyc %0d got %h want %h", cyc,
          {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
      end
`ifndef CDB_RR_EN
      n_cmp++;
      if (cdb_valid_o && cdb_tag_o == PW'(40)) begin
        n_fail++; $display("FAIL starve_fu3_leak cyc %0d got tag %0d want not 40", cyc, cdb_tag_o);
      end
`endif
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
        n_fail++; $display("FAIL starve_drain cyc %0d got %h want %h", cyc,
          {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
      end
    end
  endtask

  task automatic test_zero_reg();
    offer(1, ZTAG, 64'h5555, RW'(5));
    tick();
    idle();
    tick();
    n_cmp++;
    if ({cdb_valid_o, cdb_rob_idx_o, prf_wr_en_o} !== {1'b1, RW'(5), 1'b0}) begin
      n_fail++; $display("FAIL zero_reg got v=%b rob=%0d w=%b want 1 5 0", cdb_valid_o, cdb_rob_idx_o, prf_wr_en_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) offer(0, PW'(c + 1), {$urandom, $urandom}, RW'(c));
      else idle();
      #1;
      n_cmp++;
      if (fu_ready_o[0] !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready0 cyc %0d got %b want 1", cyc, fu_ready_o[0]);
      end
      tick();
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if ({cdb_valid_o, cdb_tag_o} !== {1'b1, PW'(c)}) begin
          n_fail++; $display("FAIL b2b_tag cyc %0d got v=%b tag=%0d want 1 %0d", cyc, cdb_valid_o, cdb_tag_o, c);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < N; i++) offer(i, PW'(50 + i), {$urandom, $urandom}, RW'(i));
    tick();
    idle();
    flush_i = 1'b1;
    offer(0, PW'(61), 64'h6161, RW'(1));
    #1;
    n_cmp++;
    if (fu_ready_o !== m_ready()) begin
      n_fail++; $display("FAIL flush_ready cyc %0d got %b want %b", cyc, fu_ready_o, m_ready());
    end
    tick();
    flush_i = 1'b0;
    idle();
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_cdb_off got v=%b w=%b want 0 0", cdb_valid_o, prf_wr_en_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (cdb_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak cyc %0d got v=%b tag=%0d want v=0", cyc, cdb_valid_o, cdb_tag_o);
      end
    end
    offer(2, PW'(62), 64'h6262, RW'(9));
    tick();
    idle();
    tick();
    n_cmp++;
    if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_data_o} !== {1'b1, 1'b1, PW'(62), 64'h6262}) begin
      n_fail++; $display("FAIL flush_recover got v=%b w=%b tag=%0d data=%h want 1 1 62 6262",
        cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_data_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fu_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        fu_tag[i]  = ($urandom_range(0, 7) == 0) ? ZTAG : PW'($urandom_range(1, 127));
        fu_data[i] = {$urandom, $urandom};
        fu_rob[i]  = RW'($urandom);
      end
      flush_i = ($urandom_range(0, 19) == 0);
      #1;
      n_cmp++;
      if (fu_ready_o !== m_ready()) begin
        n_fail++; $display("FAIL random_ready cyc %0d got %b want %b", cyc, fu_ready_o, m_ready());
      end
      tick();
      n_cmp++;
      if ({cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o} !== {m_cv, m_prf, m_ctag, m_crob, m_cdata}) begin
        n_fail++; $display("FAIL random_cdb cyc %0d got %h want %h", cyc,
          {cdb_valid_o, prf_wr_en_o, cdb_tag_o, cdb_rob_idx_o, cdb_data_o}, {m_cv, m_prf, m_ctag, m_crob, m_cdata});
      end
    end
    flush_i = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_offer();
    test_contention();
    test_starve();
    test_zero_reg();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
